// File: rtl/ppu_event_log_pkg.sv
// Shared definitions for the PPU event logger: rd_data field layout,
// event bit indices, FSM state encoding and a saturating counter helper.
package ppu_event_log_pkg;

  localparam int DEFAULT_TS_WIDTH   = 24;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  // rd_data layout: {merged, mask[7:0], timestamp[TS_WIDTH-1:0]}
  localparam int TS_LSB = 0;

  function automatic int mask_lsb(input int ts_width);
    return ts_width;
  endfunction

  function automatic int merged_bit(input int ts_width);
    return ts_width + 8;
  endfunction

  // Event mask bit order as produced by the interrupt latch
  localparam int EV_VBLANK_RISE = 0;
  localparam int EV_VBLANK_FALL = 1;
  localparam int EV_HBLANK_RISE = 2;
  localparam int EV_HBLANK_FALL = 3;
  localparam int EV_CSYNC_RISE  = 4;
  localparam int EV_CSYNC_FALL  = 5;
  localparam int EV_BURST_RISE  = 6;
  localparam int EV_BURST_FALL  = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ppu_event_log_if.sv
// Read port between the event logger (master) and the host command logic (slave).
interface ppu_event_log_if
  import ppu_event_log_pkg::*;
#(
  parameter int TS_WIDTH = DEFAULT_TS_WIDTH
);

  logic                rd_valid_o;
  logic                rd_ready_i;
  logic [TS_WIDTH+8:0] rd_data_o;

  modport master (
    output rd_valid_o,
    output rd_data_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_data_o,
    output rd_ready_i
  );

endinterface

// File: rtl/ppu_event_fifo.sv
// First-word-fall-through FIFO: rd_data always shows the head entry while
// the FIFO is non-empty, and reads zero when empty.
module ppu_event_fifo #(
  parameter int WIDTH      = 33,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (do_rd && !do_wr) count <= count - 1'b1;
    end
  end

  // Storage array; contents need no reset because empty masks rd_data
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ppu_event_log.sv
// Captures pending PPU timing events with a free-running timestamp into a
// FIFO and clears the upstream interrupt latch on the same edge. When the
// FIFO is full the latch is left set so later edges merge into one entry,
// which is tagged as merged and stamped with the time the stall began.
module ppu_event_log
  import ppu_event_log_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int TS_WIDTH   = DEFAULT_TS_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable_i,
  input  logic [7:0]          int_triggered_i,
  input  logic                int_any_triggered_i,
  output logic                int_clear_all_o,
  ppu_event_log_if.master     rd,
  output logic [DEPTH_LOG2:0] fifo_count_o,
  output logic                overflow_o,
  output logic [7:0]          overflow_count_o,
  input  logic                clear_overflow_i
);

  localparam int WIDTH = TS_WIDTH + 9;

  state_t              state;
  logic [TS_WIDTH-1:0] timestamp;
  logic [TS_WIDTH-1:0] stall_ts;
  logic                wr;
  logic                stall_enter;
  logic [WIDTH-1:0]    wr_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [WIDTH-1:0]    fifo_rd_data;

  // Free-running timestamp, independent of capture enable
  always_ff @(posedge clock) begin
    if (!reset) timestamp <= '0;
    else        timestamp <= timestamp + 1'b1;
  end

  // Decide whether this cycle writes an entry or starts a stall episode
  always_comb begin
    wr          = 1'b0;
    stall_enter = 1'b0;
    wr_data     = {1'b0, int_triggered_i, timestamp};
    case (state)
      ST_IDLE: begin
        if (enable_i && int_any_triggered_i) begin
          if (!fifo_full) wr = 1'b1;
          else            stall_enter = 1'b1;
        end
      end
      ST_STALL: begin
        if (enable_i && !fifo_full) begin
          wr      = 1'b1;
          wr_data = {1'b1, int_triggered_i, stall_ts};
        end
      end
      default: ;
    endcase
  end

  assign int_clear_all_o = wr & reset;

  // Capture FSM: remembers when a stall began and when it may end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      stall_ts <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stall_enter) begin
            state    <= ST_STALL;
            stall_ts <= timestamp;
          end
        end
        ST_STALL: begin
          if (!enable_i || !fifo_full) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow flag and saturating stall-episode counter; clear wins
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_o       <= 1'b0;
      overflow_count_o <= '0;
    end else if (clear_overflow_i) begin
      overflow_o       <= 1'b0;
      overflow_count_o <= '0;
    end else if (stall_enter) begin
      overflow_o       <= 1'b1;
      overflow_count_o <= sat_inc8(overflow_count_o);
    end
  end

  ppu_event_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (int_clear_all_o),
    .wr_data (wr_data),
    .rd_en   (rd.rd_ready_i),
    .rd_data (fifo_rd_data),
    .count   (fifo_count_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd.rd_valid_o = ~fifo_empty;
  assign rd.rd_data_o  = fifo_rd_data;

endmodule

// File: tb/tb_ppu_event_log.sv
// Directed bench for ppu_event_log: an upstream interrupt-latch model feeds
// the logger, expected entries go to a queue and are checked on each pop.
module tb_ppu_event_log;
  import ppu_event_log_pkg::*;

  logic        clock;
  logic        reset;
  logic        enable_i;
  logic [7:0]  ev;
  logic [7:0]  lat;
  logic        lat_any;
  logic        int_clear_all;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [7:0]  overflow_count;
  logic        clear_overflow;
  logic [23:0] model_ts;
  logic        clr_seen;

  logic [32:0] sb [$];
  int          n_checks;
  int          n_pass;

  ppu_event_log_if #(.TS_WIDTH(24)) rd_if ();

  ppu_event_log #(.DEPTH_LOG2(4), .TS_WIDTH(24)) dut (
    .clock               (clock),
    .reset               (reset),
    .enable_i            (enable_i),
    .int_triggered_i     (lat),
    .int_any_triggered_i (lat_any),
    .int_clear_all_o     (int_clear_all),
    .rd                  (rd_if.master),
    .fifo_count_o        (fifo_count),
    .overflow_o          (overflow),
    .overflow_count_o    (overflow_count),
    .clear_overflow_i    (clear_overflow)
  );

  assign lat_any = |lat;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Upstream sticky latch: its clear has priority over new edges
  always @(posedge clock) begin
    if (!reset)             lat <= 8'h00;
    else if (int_clear_all) lat <= 8'h00;
    else                    lat <= lat | ev;
  end

  // Reference timestamp
  always @(posedge clock) begin
    if (!reset) model_ts <= '0;
    else        model_ts <= model_ts + 24'd1;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    logic        fire;
    logic [32:0] data;
    logic [32:0] exp;
    @(negedge clock);
    fire = rd_if.rd_valid_o & rd_if.rd_ready_i;
    data = rd_if.rd_data_o;
    if (int_clear_all) clr_seen = 1'b1;
    @(posedge clock);
    #1;
    if (fire) begin
      if (sb.size() > 0) exp = sb.pop_front();
      else               exp = 'x;
      chk("rd_order", {31'd0, data}, {31'd0, exp});
    end
  endtask

  task automatic wait_ts(input logic [23:0] t);
    int g = 0;
    while (model_ts != t && g < 2000) begin
      tick();
      g++;
    end
    if (model_ts != t) begin
      n_checks++;
      $error("[TB] FAIL wait_ts: observed %h required %h", model_ts, t);
    end
  endtask

  // Pulse one event, confirm the clear strobe, record the expected entry
  task automatic push_event(input logic [7:0] m, input bit rnd_read);
    rd_if.rd_ready_i = rnd_read ? read_choice() : 1'b0;
    ev = m;
    tick();
    ev = 8'h00;
    #1;
    chk("wr_clear", {63'd0, int_clear_all}, 64'd1);
    sb.push_back({1'b0, m, model_ts});
    rd_if.rd_ready_i = rnd_read ? read_choice() : 1'b0;
    tick();
    if (rnd_read) begin
      rd_if.rd_ready_i = read_choice();
      tick();
    end
  endtask

  function automatic logic read_choice();
    if (sb.size() >= 12) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drain();
    int g = 0;
    rd_if.rd_ready_i = 1'b1;
    while (sb.size() > 0 && g < 64) begin
      tick();
      g++;
    end
    rd_if.rd_ready_i = 1'b0;
    chk("drain_count", {59'd0, fifo_count}, 64'd0);
    chk("drain_valid", {63'd0, rd_if.rd_valid_o}, 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    clr_seen = 1'b0;
    reset = 1'b0;
    enable_i = 1'b0;
    ev = 8'h00;
    clear_overflow = 1'b0;
    rd_if.rd_ready_i = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_count", {59'd0, fifo_count}, 64'd0);
    chk("rst_valid", {63'd0, rd_if.rd_valid_o}, 64'd0);
    chk("rst_data", {31'd0, rd_if.rd_data_o}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_ovc", {56'd0, overflow_count}, 64'd0);
    chk("rst_clear", {63'd0, int_clear_all}, 64'd0);

    // Idle, then an event while capture is disabled
    reset = 1'b1;
    repeat (10) tick();
    chk("idle_no_clear", {63'd0, clr_seen}, 64'd0);
    chk("idle_valid", {63'd0, rd_if.rd_valid_o}, 64'd0);
    wait_ts(24'h00000A);
    ev = 8'h01 << EV_BURST_FALL;
    tick();
    ev = 8'h00;
    wait_ts(24'h000010);
    chk("dis_no_clear", {63'd0, clr_seen}, 64'd0);
    chk("dis_count", {59'd0, fifo_count}, 64'd0);

    // Enabling with a pending latch captures it immediately
    enable_i = 1'b1;
    #1;
    chk("en_clear", {63'd0, int_clear_all}, 64'd1);
    sb.push_back({1'b0, 8'h80, model_ts});
    tick();
    chk("en_entry", {31'd0, rd_if.rd_data_o}, {31'd0, 1'b0, 8'h80, 24'h000010});
    drain();

    // Single event at timestamp 0x20
    wait_ts(24'h00001F);
    ev = 8'h01 << EV_VBLANK_RISE;
    tick();
    ev = 8'h00;
    #1;
    chk("ts20_clear", {63'd0, int_clear_all}, 64'd1);
    sb.push_back({1'b0, 8'h01, model_ts});
    tick();
    chk("ts20_entry", {31'd0, rd_if.rd_data_o}, {31'd0, 1'b0, 8'h01, 24'h000020});
    chk("ts20_count", {59'd0, fifo_count}, 64'd1);

    // Fill to 16, then stall with merged events
    for (int i = 0; i < 15; i++) push_event(8'(i + 1), 1'b0);
    chk("fill_count", {59'd0, fifo_count}, 64'd16);
    wait_ts(24'h0000FF);
    ev = 8'h01 << EV_HBLANK_RISE;
    tick();
    ev = 8'h00;
    #1;
    chk("full_no_clear", {63'd0, int_clear_all}, 64'd0);
    wait_ts(24'h000104);
    ev = 8'h01 << EV_HBLANK_FALL;
    tick();
    ev = 8'h00;
    wait_ts(24'h000110);
    chk("stall_ovc", {56'd0, overflow_count}, 64'd1);
    chk("stall_ovf", {63'd0, overflow}, 64'd1);
    rd_if.rd_ready_i = 1'b1;
    #1;
    chk("read_blocks_wr", {63'd0, int_clear_all}, 64'd0);
    tick();
    rd_if.rd_ready_i = 1'b0;
    #1;
    chk("stall_exit_clear", {63'd0, int_clear_all}, 64'd1);
    chk("stall_exit_data", {31'd0, dut.wr_data}, {31'd0, 1'b1, 8'h0C, 24'h000100});
    sb.push_back({1'b1, 8'h0C, 24'h000100});
    tick();
    chk("refill_count", {59'd0, fifo_count}, 64'd16);
    drain();

    // Interleaved writes and random reads across pointer wrap
    for (int i = 0; i < 40; i++) push_event(8'($urandom_range(1, 255)), 1'b1);
    drain();
    chk("interleave_ovc", {56'd0, overflow_count}, 64'd1);

    // Overflow counter saturation
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_ovf", {63'd0, overflow}, 64'd0);
    chk("clr_ovc", {56'd0, overflow_count}, 64'd0);
    for (int i = 0; i < 16; i++) push_event(8'h10 + 8'(i), 1'b0);
    enable_i = 1'b0;
    ev = 8'h01 << EV_CSYNC_RISE;
    tick();
    ev = 8'h00;
    clr_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      tick();
    end
    chk("sat_ovc", {56'd0, overflow_count}, 64'd255);
    chk("sat_ovf", {63'd0, overflow}, 64'd1);
    chk("sat_no_clear", {63'd0, clr_seen}, 64'd0);
    enable_i = 1'b1;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_win_ovc", {56'd0, overflow_count}, 64'd0);
    chk("clr_win_ovf", {63'd0, overflow}, 64'd0);

    // Reset in the middle of a stall
    rd_if.rd_ready_i = 1'b1;
    tick();
    rd_if.rd_ready_i = 1'b0;
    #1;
    chk("pre_rst_clear", {63'd0, int_clear_all}, 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_forces_clear", {63'd0, int_clear_all}, 64'd0);
    tick();
    sb.delete();
    chk("mid_rst_count", {59'd0, fifo_count}, 64'd0);
    chk("mid_rst_valid", {63'd0, rd_if.rd_valid_o}, 64'd0);
    chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
    chk("mid_rst_data", {31'd0, rd_if.rd_data_o}, 64'd0);
    reset = 1'b1;
    ev = 8'h01 << EV_VBLANK_FALL;
    tick();
    ev = 8'h00;
    #1;
    chk("post_rst_clear", {63'd0, int_clear_all}, 64'd1);
    sb.push_back({1'b0, 8'h02, model_ts});
    tick();
    chk("post_rst_entry", {31'd0, rd_if.rd_data_o}, {31'd0, 1'b0, 8'h02, 24'h000001});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
